instr_fetch_buffer: RTL

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

---
 rtl/instr_fetch_buffer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues one instruction-memory read at a time and
// queues fetched (or misaligned-fault) entries for the decode stage.
module instr_fetch_buffer #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_fault,
  input  logic        id_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pend_pc;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          fault_mem [DEPTH];

  logic        aligned, accept;
  logic        rsp_push, flt_push, push, pop;
  logic [31:0] push_pc, push_instr;

  assign aligned = (pc_in[1:0] == 2'b00);
  assign accept  = pc_valid & pc_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; an arriving response always ends WAIT/DRAIN, even under flush
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept && aligned) state_nxt = WAIT;
      WAIT:  begin
        if (imem_rvalid)  state_nxt = IDLE;
        else if (flush)   state_nxt = DRAIN;
      end
      DRAIN: if (imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; reset gating keeps imem_req low while reset is held
  always_comb begin
    pc_ready  = 1'b0;
    imem_req  = 1'b0;
    imem_addr = '0;
    if (reset && (state == IDLE) && !flush && (count < DEPTH_C)) pc_ready = 1'b1;
    if (pc_valid && pc_ready && aligned) begin
      imem_req  = 1'b1;
      imem_addr = pc_in;
    end
  end

  // Buffer datapath; the IDLE-only accept with count<DEPTH reserves the response slot
  assign rsp_push   = (state == WAIT) && imem_rvalid && !flush;
  assign flt_push   = accept && !aligned;
  assign push       = rsp_push | flt_push;
  assign push_pc    = rsp_push ? pend_pc : pc_in;
  assign push_instr = rsp_push ? imem_rdata : NOP_INSTR;
  assign pop        = id_valid && id_ready && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pend_pc <= '0;
    end else begin
      if (accept && aligned) pend_pc <= pc_in;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
      fault_mem[wr_ptr] <= !rsp_push;
    end
  end

  assign id_valid = (count != '0);
  assign id_pc    = id_valid ? pc_mem[rd_ptr]    : '0;
  assign id_instr = id_valid ? instr_mem[rd_ptr] : '0;
  assign id_fault = id_valid ? fault_mem[rd_ptr] : 1'b0;

endmodule
